// File: rtl/factorial_arbiter.sv
// factorial_arbiter: round-robin scheduler sharing one factorial kernel among NUM_REQ requesters,
// with a single transaction in flight and the result returned only to the granted requester.
module factorial_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]         k_n,
    output logic                          k_n_valid,
    input  logic                          k_n_ready,
    output logic                          k_start_valid,
    input  logic                          k_start_ready,
    input  logic [DATA_WIDTH-1:0]         k_out0,
    input  logic                          k_out0_valid,
    output logic                          k_out0_ready,
    input  logic                          k_end_valid,
    output logic                          k_end_ready,
    output logic [15:0]                   done_count
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3;

    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] op_q, res_q, rsp_q;
    logic [IW-1:0]         grant_q, last_grant, g, idx;
    logic                  found, n_sent, s_sent, out_seen, end_seen;
    logic                  n_done, s_done, o_done, e_done;
    logic [DATA_WIDTH-1:0] req_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign req_arr[i] = req_n[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // search begins just after the last served requester and wraps around
    always_comb begin
        found = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                g     = idx;
            end
        end
    end

    assign n_done = n_sent | k_n_ready;
    assign s_done = s_sent | k_start_ready;
    assign o_done = out_seen | k_out0_valid;
    assign e_done = end_seen | k_end_valid;

    assign req_ready     = (state == IDLE && found && rst) ? NUM_REQ'(1) << g : '0;
    assign rsp_valid     = (state == RESP) ? NUM_REQ'(1) << grant_q : '0;
    assign rsp_data      = rsp_q;
    assign k_n           = op_q;
    assign k_n_valid     = state == ISSUE && !n_sent;
    assign k_start_valid = state == ISSUE && !s_sent;
    assign k_out0_ready  = state == WAIT && !out_seen;
    assign k_end_ready   = state == WAIT && !end_seen;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            op_q       <= '0;
            res_q      <= '0;
            rsp_q      <= '0;
            grant_q    <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            n_sent     <= 1'b0;
            s_sent     <= 1'b0;
            out_seen   <= 1'b0;
            end_seen   <= 1'b0;
            done_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    op_q    <= req_arr[g];
                    grant_q <= g;
                    state   <= ISSUE;
                end
                ISSUE: begin
                    n_sent <= n_done;
                    s_sent <= s_done;
                    if (n_done && s_done) state <= WAIT;
                end
                WAIT: begin
                    if (k_out0_valid && !out_seen) res_q <= k_out0;
                    out_seen <= o_done;
                    end_seen <= e_done;
                    // rsp_q only moves here so rsp_data holds its value outside RESP
                    if (o_done && e_done) begin
                        rsp_q <= out_seen ? res_q : k_out0;
                        state <= RESP;
                    end
                end
                RESP: if (rsp_ready[grant_q]) begin
                    last_grant <= grant_q;
                    done_count <= done_count + 16'd1;
                    n_sent     <= 1'b0;
                    s_sent     <= 1'b0;
                    out_seen   <= 1'b0;
                    end_seen   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_factorial_arbiter.sv
// tb_factorial_arbiter: directed vectors with a response scoreboard and a behavioural factorial kernel
// whose handshake delays are set per test.
module tb_factorial_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] req_n = '0;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [7:0]  rsp_data;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready = 4'hF;
    logic [7:0]  k_n;
    logic        k_n_valid;
    logic        k_n_ready = 1'b0;
    logic        k_start_valid;
    logic        k_start_ready = 1'b0;
    logic [7:0]  k_out0 = '0;
    logic        k_out0_valid = 1'b0;
    logic        k_out0_ready;
    logic        k_end_valid = 1'b0;
    logic        k_end_ready;
    logic [15:0] done_count;

    factorial_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk(clk), .rst(rst), .req_n(req_n), .req_valid(req_valid), .req_ready(req_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .k_n(k_n), .k_n_valid(k_n_valid), .k_n_ready(k_n_ready),
        .k_start_valid(k_start_valid), .k_start_ready(k_start_ready),
        .k_out0(k_out0), .k_out0_valid(k_out0_valid), .k_out0_ready(k_out0_ready),
        .k_end_valid(k_end_valid), .k_end_ready(k_end_ready), .done_count(done_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] d;
    } exp_t;
    exp_t q[$];

    int total = 0, bad = 0, cyc = 0;
    int t_acc, t_rsp, t_out_hs, t_s_hs, t_wait;
    int sd = 0, od = 0, ed = 0;
    int s_cnt, ocnt, phase, nv_cyc, sv_cyc, nv_last, sv_last, early;
    bit have_n, have_s, got_o, got_e;
    logic [7:0] kn;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic post(input int i, input logic [7:0] n);
        req_n[i*8 +: 8] = n;
        req_valid[i] = 1'b1;
    endtask

    task automatic check_reset(input string p);
        check({p, "_req_ready"}, req_ready, 0);
        check({p, "_rsp_valid"}, rsp_valid, 0);
        check({p, "_k_hs"}, {k_n_valid, k_start_valid, k_out0_ready, k_end_ready}, 0);
        check({p, "_rsp_data"}, rsp_data, 0);
        check({p, "_done_count"}, done_count, 0);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 200 && done_count != 16'(target); i++) @(negedge clk);
        check("done_count", done_count, target);
    endtask

    function automatic logic [7:0] fact(input logic [7:0] n);
        int r = 1;
        for (int i = 2; i <= int'(n); i++) r = r * i;
        return 8'(r % 256);
    endfunction

    // requester side: drop valid after the accepting edge
    initial begin
        logic [3:0] clr;
        forever begin
            @(negedge clk); #2;
            clr = req_valid & req_ready;
            if (clr != 0) t_acc = cyc;
            @(posedge clk); #1;
            req_valid = req_valid & ~clr;
        end
    end

    // monitor: pop the scoreboard on every response handshake
    initial begin
        exp_t e;
        bit prev = 1'b0;
        forever begin
            @(negedge clk); #2;
            if (rsp_valid != 0 && !prev) t_rsp = cyc;
            prev = rsp_valid != 0;
            if ((rsp_valid & rsp_ready) != 0) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_rsp: got valid=%b data=%0d expected none", rsp_valid, rsp_data);
                end else begin
                    e = q.pop_front();
                    check("rsp_onehot", rsp_valid, e.oh);
                    check("rsp_data", rsp_data, e.d);
                end
            end
        end
    end

    // kernel model
    initial begin
        phase = 0; have_n = 0; have_s = 0; got_o = 0; got_e = 0; early = 0;
        nv_cyc = 0; sv_cyc = 0; s_cnt = 0; ocnt = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                phase = 0; have_n = 0; have_s = 0; got_o = 0; got_e = 0;
                nv_cyc = 0; sv_cyc = 0;
                k_n_ready = 0; k_start_ready = 0; k_out0_valid = 0; k_end_valid = 0;
            end else if (phase == 0) begin
                k_out0_valid = 0;
                k_end_valid = 0;
                k_n_ready = !have_n;
                k_start_ready = !have_s && (have_n ? s_cnt >= sd : sd == 0);
                if (k_out0_ready || k_end_ready) early++;
                nv_cyc += int'(k_n_valid);
                sv_cyc += int'(k_start_valid);
                if (have_n) s_cnt++;
                if (k_n_valid && k_n_ready) begin have_n = 1; kn = k_n; s_cnt = 1; end
                if (k_start_valid && k_start_ready) begin have_s = 1; t_s_hs = cyc; end
                if (have_n && have_s) begin
                    phase = 1; ocnt = 0; got_o = 0; got_e = 0;
                    nv_last = nv_cyc; sv_last = sv_cyc; nv_cyc = 0; sv_cyc = 0;
                end
            end else begin
                k_n_ready = 0;
                k_start_ready = 0;
                k_out0 = fact(kn);
                k_out0_valid = !got_o && ocnt >= od;
                k_end_valid = !got_e && ocnt >= ed;
                if (ocnt == 0) t_wait = k_out0_ready ? cyc : -1;
                if (k_out0_valid && k_out0_ready) begin got_o = 1; t_out_hs = cyc; end
                if (k_end_valid && k_end_ready) got_e = 1;
                ocnt++;
                if (got_o && got_e) begin phase = 0; have_n = 0; have_s = 0; end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        #3 check_reset("reset");
        @(negedge clk) rst = 1'b1;

        // single request, minimum latency
        @(negedge clk);
        q.push_back({4'b0001, 8'd120});
        post(0, 8'd5);
        wait_done(1);
        check("latency", t_rsp - t_acc, 3);

        // all four at once after a fresh reset: order 0,1,2,3
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        q.push_back({4'b0001, 8'd6});
        q.push_back({4'b0010, 8'd24});
        q.push_back({4'b0100, 8'd120});
        q.push_back({4'b1000, 8'd208});
        req_n = {8'd6, 8'd5, 8'd4, 8'd3};
        req_valid = 4'hF;
        wait_done(4);

        // end token two cycles ahead of out0
        @(negedge clk);
        od = 2;
        q.push_back({4'b0010, 8'd24});
        post(1, 8'd4);
        wait_done(5);
        check("end_first_rsp_timing", t_rsp - t_out_hs, 1);
        od = 0;

        // start accepted three cycles after operand
        @(negedge clk);
        sd = 3;
        q.push_back({4'b0100, 8'd120});
        post(2, 8'd5);
        wait_done(6);
        check("n_valid_cycles", nv_last, 1);
        check("start_valid_cycles", sv_last, 4);
        check("wait_after_start", t_wait - t_s_hs, 1);
        check("no_early_wait", early, 0);
        sd = 0;

        // requester 2 stalls its response while 0 and 3 wait
        @(negedge clk);
        rsp_ready = 4'b1011;
        q.push_back({4'b0100, 8'd176});
        post(2, 8'd7);
        for (int i = 0; i < 100 && rsp_valid != 4'b0100; i++) @(negedge clk);
        check("stall_grant", rsp_valid, 4'b0100);
        q.push_back({4'b1000, 8'd2});
        q.push_back({4'b0001, 8'd1});
        post(0, 8'd1);
        post(3, 8'd2);
        repeat (5) begin
            @(negedge clk); #3;
            check("stall_hold", {rsp_valid, rsp_data, req_ready}, {4'b0100, 8'd176, 4'b0000});
        end
        @(negedge clk) rsp_ready = 4'hF;
        wait_done(9);

        // reset while waiting on the kernel
        @(negedge clk);
        od = 3;
        post(1, 8'd3);
        for (int i = 0; i < 50 && !k_out0_ready; i++) @(negedge clk);
        check("reach_wait", k_out0_ready, 1);
        rst = 1'b0;
        od = 0;
        @(negedge clk);
        #3 check_reset("mid_reset");
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        q.push_back({4'b0010, 8'd6});
        post(1, 8'd3);
        wait_done(1);

        repeat (2) @(negedge clk);
        check("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
